dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the processor load/store path (port c) and a debug/loader master (port d) that loads and inspects memory while the core runs.
- Models a fixed-latency memory and sequences each transaction through IDLE, ACCESS, WAIT and DONE.
- Gives each requester a one-cycle completion pulse, plus a stall hint for the core.

---
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (core/debug) arbiter in front of a fixed-latency data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; default is fixed core priority.
module dmem_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            c_req,
  input  logic            c_we,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  input  logic [DW/8-1:0] c_wmask,
  output logic [DW-1:0]   c_rdata,
  output logic            c_done,
  output logic            c_stall,

  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,

  output logic            m_en,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  input  logic [DW-1:0]   m_rdata,

  output logic            busy,
  output logic            owner
);

  localparam int unsigned MW = DW / 8;
  localparam int unsigned CW = $clog2(LAT + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [MW-1:0] m_wmask_q, m_wmask_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          gnt;
  logic          enter_done;

`ifdef DMEM_ARB_RR_EN
  logic          last_q, last_d;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt = d_req;
    if (c_req && d_req) begin
      gnt = ~last_q;
    end
  end
`else
  always_comb begin
    gnt = d_req & ~c_req;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wmask_d = m_wmask_q;
`ifdef DMEM_ARB_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (c_req || d_req) begin
          state_d   = StAccess;
          owner_d   = gnt;
          m_we_d    = gnt ? d_we    : c_we;
          m_addr_d  = gnt ? d_addr  : c_addr;
          m_wdata_d = gnt ? d_wdata : c_wdata;
          m_wmask_d = gnt ? d_wmask : c_wmask;
        end
      end
      StAccess: begin
        if (LAT == 1) begin
          state_d = StDone;
        end else begin
          cnt_d   = CW'(LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef DMEM_ARB_RR_EN
        last_d  = owner_q;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Read data is sampled on the edge that moves the FSM into DONE.
  assign enter_done = (state_d == StDone) && (state_q != StDone);

  always_comb begin
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    if (enter_done && !m_we_q) begin
      if (owner_q) begin
        d_rdata_d = m_rdata;
      end else begin
        c_rdata_d = m_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmask_q <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wmask_q <= m_wmask_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef DMEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign m_en    = (state_q == StAccess);
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wmask = m_wmask_q;
  assign busy    = (state_q != StIdle);
  assign owner   = owner_q;
  assign c_done  = (state_q == StDone) && !owner_q;
  assign d_done  = (state_q == StDone) && owner_q;
  assign c_stall = c_req & ~c_done;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: three instances (LAT = 1, 3, 4) driven in turn
// against a transaction-level model of arbitration, timing and read-data capture.
module tb_dmem_arbiter;

  localparam int NI = 3;

  logic        clk;
  logic        rst     [NI];
  logic        c_req   [NI];
  logic        c_we    [NI];
  logic [31:0] c_addr  [NI];
  logic [31:0] c_wdata [NI];
  logic [3:0]  c_wmask [NI];
  logic [31:0] c_rdata [NI];
  logic        c_done  [NI];
  logic        c_stall [NI];
  logic        d_req   [NI];
  logic        d_we    [NI];
  logic [31:0] d_addr  [NI];
  logic [31:0] d_wdata [NI];
  logic [3:0]  d_wmask [NI];
  logic [31:0] d_rdata [NI];
  logic        d_done  [NI];
  logic        m_en    [NI];
  logic        m_we    [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic [3:0]  m_wmask [NI];
  logic [31:0] m_rdata [NI];
  logic        busy    [NI];
  logic        owner   [NI];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          last_m;
  logic [31:0] crd_m;
  logic [31:0] drd_m;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_arbiter #(
      .AW (32),
      .DW (32),
      .LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk    (clk),
      .rst    (rst[g]),
      .c_req  (c_req[g]),
      .c_we   (c_we[g]),
      .c_addr (c_addr[g]),
      .c_wdata(c_wdata[g]),
      .c_wmask(c_wmask[g]),
      .c_rdata(c_rdata[g]),
      .c_done (c_done[g]),
      .c_stall(c_stall[g]),
      .d_req  (d_req[g]),
      .d_we   (d_we[g]),
      .d_addr (d_addr[g]),
      .d_wdata(d_wdata[g]),
      .d_wmask(d_wmask[g]),
      .d_rdata(d_rdata[g]),
      .d_done (d_done[g]),
      .m_en   (m_en[g]),
      .m_we   (m_we[g]),
      .m_addr (m_addr[g]),
      .m_wdata(m_wdata[g]),
      .m_wmask(m_wmask[g]),
      .m_rdata(m_rdata[g]),
      .busy   (busy[g]),
      .owner  (owner[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  // Arbitration rule: lone requester wins; ties per build option.
  function automatic bit pick(input bit rc, input bit rd);
    if (rc && !rd) return 1'b0;
    if (rd && !rc) return 1'b1;
`ifdef DMEM_ARB_RR_EN
    return ~last_m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic chk_reset(input int k);
    chk("rst_men", k, m_en[k], 0);
    chk("rst_busy", k, busy[k], 0);
    chk("rst_dones", k, {c_done[k], d_done[k]}, 0);
    chk("rst_owner", k, owner[k], 0);
    chk("rst_mwe", k, m_we[k], 0);
    chk("rst_maddr", k, m_addr[k], 0);
    chk("rst_mwdata", k, m_wdata[k], 0);
    chk("rst_mwmask", k, m_wmask[k], 0);
    chk("rst_crdata", k, c_rdata[k], 0);
    chk("rst_drdata", k, d_rdata[k], 0);
  endtask

  task automatic new_txn(input int k, input bit p);
    if (!p) begin
      c_we[k]    = 1'($urandom_range(0, 1));
      c_addr[k]  = $urandom;
      c_wdata[k] = $urandom;
      c_wmask[k] = 4'($urandom_range(0, 15));
    end else begin
      d_we[k]    = 1'($urandom_range(0, 1));
      d_addr[k]  = $urandom;
      d_wdata[k] = $urandom;
      d_wmask[k] = 4'($urandom_range(0, 15));
    end
  endtask

  // Entered at a negedge in an IDLE cycle with requests already driven; nc/nd are
  // the numbers of back-to-back transactions each port wants.
  task automatic serve(input int k, input int nc_in, input int nd_in);
    int          nc;
    int          nd;
    bit          w;
    logic        we_w;
    logic [31:0] mrd;
    nc = nc_in;
    nd = nd_in;
    while (nc + nd > 0) begin
      w = pick(nc > 0, nd > 0);
      chk("idle_busy", k, busy[k], 0);
      chk("idle_men", k, m_en[k], 0);
      @(negedge clk);
      chk("acc_men", k, m_en[k], 1);
      chk("acc_busy", k, busy[k], 1);
      chk("acc_owner", k, owner[k], w);
      chk("acc_mwe", k, m_we[k], w ? d_we[k] : c_we[k]);
      chk("acc_maddr", k, m_addr[k], w ? d_addr[k] : c_addr[k]);
      chk("acc_mwdata", k, m_wdata[k], w ? d_wdata[k] : c_wdata[k]);
      chk("acc_mwmask", k, m_wmask[k], w ? d_wmask[k] : c_wmask[k]);
      chk("acc_stall", k, c_stall[k], nc > 0);
      for (int i = 1; i < lat(k); i++) begin
        @(negedge clk);
        chk("wait_men", k, m_en[k], 0);
        chk("wait_busy", k, busy[k], 1);
        chk("wait_dones", k, {c_done[k], d_done[k]}, 0);
      end
      @(negedge clk);
      we_w = w ? d_we[k] : c_we[k];
      mrd  = m_rdata[k];
      if (!we_w) begin
        if (w) drd_m = mrd;
        else   crd_m = mrd;
      end
      chk("done_c", k, c_done[k], !w);
      chk("done_d", k, d_done[k], w);
      chk("done_men", k, m_en[k], 0);
      chk("done_busy", k, busy[k], 1);
      chk("done_crdata", k, c_rdata[k], crd_m);
      chk("done_drdata", k, d_rdata[k], drd_m);
      chk("done_stall", k, c_stall[k], (nc > 0) && w);
      last_m = w;
      if (!w) begin
        nc--;
        if (nc > 0) new_txn(k, 1'b0);
        else c_req[k] = 1'b0;
      end else begin
        nd--;
        if (nd > 0) new_txn(k, 1'b1);
        else d_req[k] = 1'b0;
      end
      m_rdata[k] = $urandom;
      @(negedge clk);
    end
    chk("end_busy", k, busy[k], 0);
    chk("end_crdata", k, c_rdata[k], crd_m);
    chk("end_drdata", k, d_rdata[k], drd_m);
  endtask

  task automatic start(input int k, input int nc, input int nd);
    if (nc > 0) begin
      new_txn(k, 1'b0);
      c_req[k] = 1'b1;
    end
    if (nd > 0) begin
      new_txn(k, 1'b1);
      d_req[k] = 1'b1;
    end
    m_rdata[k] = $urandom;
    serve(k, nc, nd);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k]     = 1'b0;
      c_req[k]   = 1'b0;
      c_we[k]    = 1'b0;
      c_addr[k]  = '0;
      c_wdata[k] = '0;
      c_wmask[k] = '0;
      d_req[k]   = 1'b0;
      d_we[k]    = 1'b0;
      d_addr[k]  = '0;
      d_wdata[k] = '0;
      d_wmask[k] = '0;
      m_rdata[k] = '0;
    end
    @(negedge clk);

    for (int k = 0; k < NI; k++) begin
      // Reset held with a pending core read of 0x10.
      c_we[k]    = 1'b0;
      c_addr[k]  = 32'h10;
      c_req[k]   = 1'b1;
      m_rdata[k] = 32'hDEADBEEF;
      repeat (2) begin
        @(negedge clk);
        chk_reset(k);
      end
      last_m = 1'b1;
      crd_m  = '0;
      drd_m  = '0;
      rst[k] = 1'b1;
      serve(k, 1, 0);
      chk("read_deadbeef", k, c_rdata[k], 32'hDEADBEEF);

      // Debug write leaves both rdata registers alone.
      d_we[k]    = 1'b1;
      d_addr[k]  = 32'h20;
      d_wdata[k] = 32'h12345678;
      d_wmask[k] = 4'hF;
      d_req[k]   = 1'b1;
      m_rdata[k] = 32'h55AA55AA;
      serve(k, 0, 1);
      chk("write_crdata", k, c_rdata[k], 32'hDEADBEEF);

      // Simultaneous requests held over several transactions.
      start(k, 2, 1);
      start(k, 2, 2);

      // Back-to-back core reads of 0xA then 0xB.
      c_we[k]    = 1'b0;
      c_addr[k]  = 32'h40;
      c_req[k]   = 1'b1;
      m_rdata[k] = 32'hA;
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 + lat(k) && !seen; i++) begin
          @(negedge clk);
          seen = c_done[k];
        end
        chk("b2b_first_done", k, seen, 1);
        chk("b2b_first_data", k, c_rdata[k], 32'hA);
        m_rdata[k] = 32'hB;
        repeat (1 + lat(k)) @(negedge clk);
        chk("b2b_gap_nodone", k, c_done[k], 0);
        chk("b2b_gap_stall", k, c_stall[k], 1);
        @(negedge clk);
        chk("b2b_second_done", k, c_done[k], 1);
        chk("b2b_second_data", k, c_rdata[k], 32'hB);
        chk("b2b_second_stall", k, c_stall[k], 0);
        c_req[k] = 1'b0;
        crd_m    = 32'hB;
        last_m   = 1'b0;
        @(negedge clk);
      end

      // Randomized traffic.
      repeat (8) begin
        int nc;
        int nd;
        nc = $urandom_range(0, 2);
        nd = $urandom_range(0, 2);
        if (nc + nd == 0) nc = 1;
        start(k, nc, nd);
      end

      // Reset landing in WAIT aborts the access with no done pulse.
      if (lat(k) > 1) begin
        new_txn(k, 1'b0);
        c_req[k]   = 1'b1;
        m_rdata[k] = $urandom;
        @(negedge clk);
        chk("abort_men", k, m_en[k], 1);
        @(negedge clk);
        chk("abort_wait", k, {m_en[k], busy[k]}, 2'b01);
        rst[k] = 1'b0;
        @(negedge clk);
        chk_reset(k);
        last_m = 1'b1;
        crd_m  = '0;
        drd_m  = '0;
        rst[k] = 1'b1;
        serve(k, 1, 0);
        start(k, 1, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
